ack_generator: RTL

Receive-side ACK stage between the router's local-delivery port and the transmit arbiter. It accepts flits addressed to this node, filters out non-ackable or corrupt ones, and builds the ACK flit (src/dst swapped, checksum recomputed) through `make_ack_comb`. Pending ACKs are held in a small FIFO and drained over a valid/ready handshake to the transmit path.

---
 rtl/types.sv | 47 ++++
 rtl/make_ack_comb.sv | 20 ++
 rtl/ack_generator.sv | 107 ++++++++++
 3 files changed

// File: rtl/types.sv
// Shared flit definitions and checksum helpers for the receive/ACK path.
// The checksum is an XOR of all header+payload bytes, seeded so an all-zero flit is invalid.
package types;

  typedef logic [3:0] node_id_t;

  typedef enum logic [2:0] {
    FT_NOP  = 3'd0,
    FT_HEAD = 3'd1,
    FT_BODY = 3'd2,
    FT_TAIL = 3'd3,
    FT_ACK  = 3'd4
  } flittype_t;

  typedef struct packed {
    flittype_t  flittype;
    node_id_t   src_id;
    node_id_t   dst_id;
    logic [7:0] flit_id;
    logic [4:0] rsvd;
  } header_t;

  typedef struct packed {
    header_t     header;
    logic [15:0] payload;
    logic [7:0]  checksum;
  } flit_t;

  // Identity of a delivered flit, used to suppress repeated ACKs
  typedef struct packed {
    node_id_t   src_id;
    logic [7:0] flit_id;
  } ack_key_t;

  localparam logic [7:0] CSUM_SEED = 8'h5A;

  function automatic logic [7:0] calculate_checksum_comb(input flit_t f);
    logic [39:0] b;
    b = {f.header, f.payload};
    return b[39:32] ^ b[31:24] ^ b[23:16] ^ b[15:8] ^ b[7:0] ^ CSUM_SEED;
  endfunction

  function automatic logic checksum_ok(input flit_t f);
    return f.checksum == calculate_checksum_comb(f);
  endfunction

endpackage

// File: rtl/make_ack_comb.sv
// Turns an (already ACK-typed) received flit into its ACK: swaps src/dst and
// recomputes the checksum over the final header.
module make_ack_comb
  import types::*;
(
  input  flit_t flit_in,
  output flit_t ack_flit
);

  flit_t a;

  always_comb begin
    a               = flit_in;
    a.header.src_id = flit_in.header.dst_id;
    a.header.dst_id = flit_in.header.src_id;
    a.checksum      = calculate_checksum_comb(a);
    ack_flit        = a;
  end

endmodule

// File: rtl/ack_generator.sv
// Receive-side ACK stage: S1 capture/filter, ACK build, FWFT ACK FIFO.
// Optional ACK_DEDUP_EN suppresses an ACK repeating the last pushed (src_id, flit_id).
module ack_generator
  import types::*;
#(
  parameter int DEPTH      = 4,
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  node_id_t              this_node_id,
  input  logic                  flit_in_valid,
  input  flit_t                 flit_in,
  output logic                  flit_in_ready,
  output logic                  ack_out_valid,
  output flit_t                 ack_out,
  input  logic                  ack_out_ready,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic          s1_valid;
  flit_t         s1_flit;
  flit_t         s1_typed;
  flit_t         ack_flit;
  flit_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, occ;
  logic          accept, type_ok, dst_ok, csum_ok, ackable, push, pop, drop_inc;

  assign accept = flit_in_valid & flit_in_ready;

  always_comb begin
    s1_typed                 = s1_flit;
    s1_typed.header.flittype = FT_ACK;
    type_ok = s1_flit.header.flittype inside {FT_HEAD, FT_BODY, FT_TAIL};
    dst_ok  = s1_flit.header.dst_id == this_node_id;
    csum_ok = checksum_ok(s1_flit);
    ackable = s1_valid & type_ok & dst_ok & csum_ok;
  end

  make_ack_comb u_make_ack (
    .flit_in  (s1_typed),
    .ack_flit (ack_flit)
  );

`ifdef ACK_DEDUP_EN
  logic     last_ack_valid;
  ack_key_t last_ack;
  logic     dup_hit;

  assign dup_hit  = last_ack_valid &&
                    (last_ack == ack_key_t'{s1_flit.header.src_id, s1_flit.header.flit_id});
  assign push     = ackable & ~dup_hit;
  assign drop_inc = s1_valid & (~csum_ok | (ackable & dup_hit));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_ack_valid <= 1'b0;
      last_ack       <= '0;
    end else if (push) begin
      last_ack_valid <= 1'b1;
      last_ack       <= ack_key_t'{s1_flit.header.src_id, s1_flit.header.flit_id};
    end
  end
`else
  assign push     = ackable;
  assign drop_inc = s1_valid & ~csum_ok;
`endif

  // Ready reserves a slot for whatever sits in S1, so a push never meets a full FIFO
  assign occ           = count + CW'(s1_valid);
  assign flit_in_ready = occ < DEPTH_C;
  assign ack_out_valid = count != '0;
  assign ack_out       = mem[rd_ptr];
  assign pop           = ack_out_valid & ack_out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_flit    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_flit <= flit_in;
      if (push) begin
        mem[wr_ptr] <= ack_flit;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (drop_inc && !(&drop_count)) drop_count <= drop_count + 1'b1;
    end
  end

endmodule
